mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Data-memory access stage of the 5-stage pipelined CPU. It replaces the pass-through MEM stage between EX/MEM and MEM/WB. LOAD and STORE instructions access an external synchronous data RAM with a parameterised read latency. All other instructions pass straight through to MEM/WB in one cycle. While a load is waiting for RAM data, the block raises `mem_stall` to freeze the upstream stages, and it inserts bubbles into WB.

## Interface
Parameters:
- `ADDR_W`, 8: data RAM address width; the address is the low `ADDR_W` bits of `ex_mem_result`.
- `DATA_W`, 32: datapath width.
- `RD_LAT`, 1: RAM read latency in clocks; legal range 1..3.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset: asynchronous, active-low.
- `ex_mem_instruct`  in  8  instruction word. Bits [6:4] are the opcode, [3:2] are rd, [1:0] are rs, and bit [7] is ignored.
- `ex_mem_regwrite`  in  1  regwrite flag from EX.
- `ex_mem_wb_enc`  in  2  destination register encoding.
- `ex_mem_result`  in  DATA_W  ALU result; also the load/store address.
- `ex_mem_store_data`  in  DATA_W  store data (value of rs).
- `mem_stall`  out  1  freezes IF/ID/EX and holds the EX/MEM inputs.
- `dmem_addr`  out  ADDR_W  RAM address.
- `dmem_wdata`  out  DATA_W  RAM write data.
- `dmem_wren`  out  1  RAM write enable.
- `dmem_rdata`  in  DATA_W  RAM read data, valid `RD_LAT` edges after the address is presented.
- `mem_wb_regwrite`  out  1  MEM/WB regwrite.
- `mem_wb_wb_enc`  out  2  MEM/WB destination register.
- `mem_wb_result`  out  DATA_W  MEM/WB writeback data.
- `wb_instruct`  out  8  instruction word forwarded to the HDU.
- `load_count`  out  16  number of completed loads; wraps.
- `store_count`  out  16  number of completed stores; wraps.

## Operation
- Opcodes:
  - LOAD = 3'b100.
  - STORE = 3'b101.
  - Every other opcode, including NOP 3'b000, ADD 3'b001 and INC 3'b011, is a pass-through.
- State machine states: IDLE and WAIT. A down-counter `cnt` of 2 bits is used in WAIT.
- IDLE with a pass-through instruction:
  - `mem_stall`=0.
  - At the clock edge, MEM/WB registers the input fields unchanged.
- IDLE with STORE:
  - `dmem_wren`=1 combinationally, `dmem_addr`=`ex_mem_result[ADDR_W-1:0]`, `dmem_wdata`=`ex_mem_store_data`.
  - No stall.
  - At the edge, MEM/WB gets `regwrite`=0, `wb_instruct`=the input word, `result`=`ex_mem_result`, and `store_count`++.
- IDLE with LOAD:
  - `dmem_addr` is driven from the input and `mem_stall`=1.
  - At the edge, latch address, `wb_enc` and `instruct`; set `cnt`<=`RD_LAT`-1; go to WAIT.
  - MEM/WB takes a bubble.
- WAIT:
  - `dmem_addr` = the latched address; `dmem_wren`=0; the EX/MEM inputs are ignored.
  - If `cnt`!=0: `mem_stall`=1; at the edge `cnt`--, and MEM/WB takes a bubble.
  - If `cnt`==0: `mem_stall`=0. At the edge, MEM/WB gets `regwrite`=1, `wb_enc`=the latched value, `result`=`dmem_rdata`, `wb_instruct`=the latched word; `load_count`++; go to IDLE.
- Bubble: `mem_wb_regwrite`=0, `mem_wb_wb_enc`=0, `mem_wb_result`=0, `wb_instruct`=8'h00.
- For LOAD, the `ex_mem_regwrite` input is ignored and regwrite is forced to 1. For STORE it is forced to 0.
- The upper address bits above `ADDR_W` are ignored, so the address wraps modulo 2^`ADDR_W`.

## Timing
- Pass-through and STORE: latency 1 cycle, throughput 1 per cycle.
- LOAD:
  - Occupies 1+`RD_LAT` cycles.
  - `mem_stall` is high for exactly `RD_LAT` consecutive cycles, starting in the cycle the LOAD appears.
  - `mem_stall` is low in the completion cycle, so upstream advances on the same edge that writes the result.
- Back-to-back LOADs: the second LOAD is presented in the cycle after completion and restarts the sequence with no extra gap.
- A STORE immediately after a LOAD executes in the cycle following load completion. The RAM never sees a read and a write in the same cycle.
- Reset values (asynchronous):
  - State IDLE, `cnt`=0.
  - All MEM/WB outputs 0, `wb_instruct`=8'h00.
  - `load_count`=`store_count`=0.
  - `mem_stall`=0 and `dmem_wren`=0 while `resetn` is low.
- Reset during WAIT: the load is abandoned, no writeback occurs, the counters clear, and `mem_stall` drops immediately.
- `load_count` and `store_count` wrap from 16'hFFFF to 0.

## Test plan
- Pass-through:
  - Stimulus: ADD (8'h11), `result`=32'd7, `wb_enc`=0, `regwrite`=1.
  - Required: one edge later `mem_wb_result`=7, `mem_wb_regwrite`=1, `wb_instruct`=8'h11, `mem_stall` never high.
- STORE then LOAD, `RD_LAT`=1:
  - Stimulus: STORE 8'h51 with `result`=32'h105 and data 32'hDEAD; then LOAD 8'h44 with `result`=5.
  - Required: the STORE cycle drives `dmem_addr`=5 with `dmem_wren`=1. The LOAD gives `mem_stall`=1 for 1 cycle, one bubble, then `mem_wb_result`=32'hDEAD with `wb_enc`=1. `load_count`=1 and `store_count`=1.
- `RD_LAT`=3, back-to-back LOADs:
  - Required: `mem_stall` high 3 cycles, low 1, high 3, low 1.
  - 3 bubbles precede each result.
  - `dmem_addr` stays stable through each WAIT even if `ex_mem_result` is toggled.
- Reset mid-load:
  - Stimulus: assert `resetn`=0 in the second WAIT cycle (`RD_LAT`=3).
  - Required: `mem_stall`=0 and all outputs 0 immediately. After release, an ADD passes through normally and `load_count`=0.
- Counter wrap:
  - Stimulus: preload `store_count` to 16'hFFFF via 65535 stores, then issue one more STORE.
  - Required: `store_count`=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// Data-memory access stage: a LOAD or STORE goes to a synchronous RAM with read latency RD_LAT.
// Every other opcode passes to MEM/WB in one cycle. While a load is waiting, upstream is stalled and WB receives bubbles.
module mem_access_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        ex_mem_instruct,
  input  logic              ex_mem_regwrite,
  input  logic [1:0]        ex_mem_wb_enc,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic [DATA_W-1:0] ex_mem_store_data,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_wb_regwrite,
  output logic [1:0]        mem_wb_wb_enc,
  output logic [DATA_W-1:0] mem_wb_result,
  output logic [7:0]        wb_instruct,
  output logic [15:0]       load_count,
  output logic [15:0]       store_count
);

  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        enc_q;
  logic [7:0]        instr_q;
  logic              regwrite_q;
  logic [1:0]        wb_enc_q;
  logic [DATA_W-1:0] result_q;
  logic [7:0]        wb_instr_q;
  logic [15:0]       load_cnt_q;
  logic [15:0]       store_cnt_q;

  logic is_load;
  logic is_store;

  assign is_load  = (ex_mem_instruct[6:4] == OP_LOAD);
  assign is_store = (ex_mem_instruct[6:4] == OP_STORE);

  // Stall and write enable are gated by resetn so that they drop as soon as reset is asserted.
  assign mem_stall  = resetn && (((state_q == IDLE) && is_load) ||
                                 ((state_q == WAIT) && (cnt_q != 2'd0)));
  assign dmem_wren  = resetn && (state_q == IDLE) && is_store;
  assign dmem_addr  = (state_q == WAIT) ? addr_q : ex_mem_result[ADDR_W-1:0];
  assign dmem_wdata = ex_mem_store_data;

  assign mem_wb_regwrite = regwrite_q;
  assign mem_wb_wb_enc   = wb_enc_q;
  assign mem_wb_result   = result_q;
  assign wb_instruct     = wb_instr_q;
  assign load_count      = load_cnt_q;
  assign store_count     = store_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      addr_q      <= '0;
      enc_q       <= 2'd0;
      instr_q     <= 8'h00;
      regwrite_q  <= 1'b0;
      wb_enc_q    <= 2'd0;
      result_q    <= '0;
      wb_instr_q  <= 8'h00;
      load_cnt_q  <= 16'd0;
      store_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_load) begin
            addr_q     <= ex_mem_result[ADDR_W-1:0];
            enc_q      <= ex_mem_wb_enc;
            instr_q    <= ex_mem_instruct;
            cnt_q      <= CNT_INIT;
            state_q    <= WAIT;
            regwrite_q <= 1'b0;
            wb_enc_q   <= 2'd0;
            result_q   <= '0;
            wb_instr_q <= 8'h00;
          end else begin
            regwrite_q <= is_store ? 1'b0 : ex_mem_regwrite;
            wb_enc_q   <= ex_mem_wb_enc;
            result_q   <= ex_mem_result;
            wb_instr_q <= ex_mem_instruct;
            if (is_store) store_cnt_q <= store_cnt_q + 16'd1;
          end
        end
        WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q      <= cnt_q - 2'd1;
            regwrite_q <= 1'b0;
            wb_enc_q   <= 2'd0;
            result_q   <= '0;
            wb_instr_q <= 8'h00;
          end else begin
            regwrite_q <= 1'b1;
            wb_enc_q   <= enc_q;
            result_q   <= dmem_rdata;
            wb_instr_q <= instr_q;
            load_cnt_q <= load_cnt_q + 16'd1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The address uses only the low bits of the result, so the upper bits are deliberately left unused.
  logic unused_hi;
  assign unused_hi = ^ex_mem_result;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench: two instances, one with RD_LAT=1 and one with RD_LAT=3, each attached to its own behavioural RAM.
module tb_mem_access_stage;

  logic        clk;
  logic        resetn;
  logic [7:0]  instr1, instr3;
  logic        regwrite;
  logic [1:0]  enc;
  logic [31:0] result, sdata;

  logic        stall1, wren1, rw1;
  logic [7:0]  addr1, wbi1;
  logic [31:0] wdata1, rdata1, res1;
  logic [1:0]  enc1;
  logic [15:0] lc1, sc1;

  logic        stall3, wren3, rw3;
  logic [7:0]  addr3, wbi3;
  logic [31:0] wdata3, rdata3, res3;
  logic [1:0]  enc3;
  logic [15:0] lc3, sc3;

  int passed = 0;
  int total  = 0;

  mem_access_stage #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u1 (
    .clk(clk), .resetn(resetn), .ex_mem_instruct(instr1), .ex_mem_regwrite(regwrite),
    .ex_mem_wb_enc(enc), .ex_mem_result(result), .ex_mem_store_data(sdata),
    .mem_stall(stall1), .dmem_addr(addr1), .dmem_wdata(wdata1), .dmem_wren(wren1),
    .dmem_rdata(rdata1), .mem_wb_regwrite(rw1), .mem_wb_wb_enc(enc1), .mem_wb_result(res1),
    .wb_instruct(wbi1), .load_count(lc1), .store_count(sc1));

  mem_access_stage #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u3 (
    .clk(clk), .resetn(resetn), .ex_mem_instruct(instr3), .ex_mem_regwrite(regwrite),
    .ex_mem_wb_enc(enc), .ex_mem_result(result), .ex_mem_store_data(sdata),
    .mem_stall(stall3), .dmem_addr(addr3), .dmem_wdata(wdata3), .dmem_wren(wren3),
    .dmem_rdata(rdata3), .mem_wb_regwrite(rw3), .mem_wb_wb_enc(enc3), .mem_wb_result(res3),
    .wb_instruct(wbi3), .load_count(lc3), .store_count(sc3));

  // Synchronous RAMs: one read-pipeline stage per clock of latency.
  logic [31:0] ram1 [256];
  logic [31:0] ram3 [256];
  logic [31:0] p0, p1, p2;

  always @(posedge clk) begin
    if (wren1) ram1[addr1] <= wdata1;
    rdata1 <= ram1[addr1];
  end

  always @(posedge clk) begin
    if (wren3) ram3[addr3] <= wdata3;
    p0 <= ram3[addr3];
    p1 <= p0;
    p2 <= p1;
  end
  assign rdata3 = p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0] stall_exp;

  initial begin
    resetn   = 1'b0;
    instr1   = 8'h44;
    instr3   = 8'h51;
    regwrite = 1'b1;
    enc      = 2'd0;
    result   = 32'd5;
    sdata    = 32'h1234;
    stall_exp = 8'b0111_0111;

    // Reset state; a LOAD or STORE on the inputs must not leak through
    #12;
    chk("rst_stall1", stall1, 0);
    chk("rst_wren3", wren3, 0);
    chk("rst_rw1", rw1, 0);
    chk("rst_res1", res1, 0);
    chk("rst_wbi1", wbi1, 0);
    chk("rst_lc1", lc1, 0);
    chk("rst_sc3", sc3, 0);
    tick();
    resetn = 1'b1;

    // Pass-through ADD on both instances
    instr1 = 8'h11; instr3 = 8'h11; result = 32'd7; enc = 2'd0; regwrite = 1'b1;
    #1;
    chk("add_stall1", stall1, 0);
    chk("add_stall3", stall3, 0);
    tick();
    chk("add_res1", res1, 32'd7);
    chk("add_rw1", rw1, 1);
    chk("add_wbi1", wbi1, 8'h11);
    chk("add_res3", res3, 32'd7);

    // Two STOREs to both RAMs: addr 6 <- BEEF, then 0x105 (wraps to 5) <- DEAD
    instr1 = 8'h51; instr3 = 8'h51; result = 32'd6; sdata = 32'hBEEF; enc = 2'd2;
    tick();
    result = 32'h105; sdata = 32'hDEAD;
    #1;
    chk("st_addr1", addr1, 32'd5);
    chk("st_wren1", wren1, 1);
    chk("st_wdata1", wdata1, 32'hDEAD);
    chk("st_stall1", stall1, 0);
    tick();
    chk("st_rw1", rw1, 0);
    chk("st_wbi1", wbi1, 8'h51);
    chk("st_res1", res1, 32'h105);
    chk("st_sc1", sc1, 2);

    // LOAD with RD_LAT=1: one stall cycle, one bubble, then the data
    instr1 = 8'h44; instr3 = 8'h00; result = 32'd5; enc = 2'd1; regwrite = 1'b0;
    #1;
    chk("ld1_stall", stall1, 1);
    chk("ld1_addr", addr1, 32'd5);
    chk("ld1_wren", wren1, 0);
    tick();
    chk("ld1_bub_rw", rw1, 0);
    chk("ld1_bub_res", res1, 0);
    chk("ld1_bub_wbi", wbi1, 0);
    instr1 = 8'h00; result = 32'h77;
    #1;
    chk("ld1_done_stall", stall1, 0);
    chk("ld1_wait_addr", addr1, 32'd5);
    tick();
    chk("ld1_res", res1, 32'hDEAD);
    chk("ld1_rw", rw1, 1);
    chk("ld1_enc", enc1, 1);
    chk("ld1_wbi", wbi1, 8'h44);
    chk("ld1_lc", lc1, 1);
    chk("ld1_sc", sc1, 2);

    // Back-to-back LOADs with RD_LAT=3; the result input is toggled during each WAIT
    for (int c = 0; c < 8; c++) begin
      instr3 = (c == 0) ? 8'h44 : (c == 4) ? 8'h48 : 8'h00;
      enc    = (c < 4) ? 2'd1 : 2'd2;
      result = (c == 0) ? 32'd5 : (c == 4) ? 32'd6 : (32'hA0 + 32'(c));
      #1;
      chk($sformatf("b2b_stall_c%0d", c), stall3, stall_exp[c]);
      if (c != 0 && c != 4) chk($sformatf("b2b_addr_c%0d", c), addr3, (c < 4) ? 32'd5 : 32'd6);
      tick();
      chk($sformatf("b2b_rw_c%0d", c), rw3, (c == 3 || c == 7) ? 1 : 0);
      if (c == 3) chk("b2b_res_a", res3, 32'hDEAD);
      if (c == 7) chk("b2b_res_b", res3, 32'hBEEF);
      if (c == 7) chk("b2b_enc_b", enc3, 2);
    end
    chk("b2b_lc3", lc3, 2);

    // Reset asserted in the second WAIT cycle of an RD_LAT=3 load
    instr3 = 8'h44; result = 32'd5; enc = 2'd1;
    tick();
    instr3 = 8'h00;
    tick();
    chk("mid_stall_pre", stall3, 1);
    resetn = 1'b0;
    #1;
    chk("mid_stall", stall3, 0);
    chk("mid_rw", rw3, 0);
    chk("mid_res", res3, 0);
    chk("mid_wbi", wbi3, 0);
    chk("mid_lc", lc3, 0);
    chk("mid_sc", sc3, 0);
    #3;
    resetn = 1'b1;
    tick();
    instr3 = 8'h11; result = 32'd7; enc = 2'd0; regwrite = 1'b1;
    #1;
    chk("post_stall", stall3, 0);
    tick();
    chk("post_res", res3, 32'd7);
    chk("post_rw", rw3, 1);
    chk("post_wbi", wbi3, 8'h11);
    chk("post_lc", lc3, 0);

    // store_count wrap on the RD_LAT=1 instance
    instr1 = 8'h51; instr3 = 8'h00; result = 32'd9; sdata = 32'h1;
    for (int i = 0; i < 65535; i++) tick();
    chk("wrap_ffff", sc1, 16'hFFFF);
    tick();
    chk("wrap_zero", sc1, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
